// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver and decoder
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } rx_state_e;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] K_ENTER  = 8'd128;
    localparam logic [7:0] K_BKSP   = 8'd129;
    localparam logic [7:0] K_LEFT   = 8'd130;
    localparam logic [7:0] K_UP     = 8'd131;
    localparam logic [7:0] K_RIGHT  = 8'd132;
    localparam logic [7:0] K_DOWN   = 8'd133;
    localparam logic [7:0] K_HOME   = 8'd134;
    localparam logic [7:0] K_END    = 8'd135;
    localparam logic [7:0] K_PGUP   = 8'd136;
    localparam logic [7:0] K_PGDN   = 8'd137;
    localparam logic [7:0] K_INSERT = 8'd138;
    localparam logic [7:0] K_DELETE = 8'd139;
    localparam logic [7:0] K_ESC    = 8'd140;
    localparam logic [7:0] K_F1     = 8'd141;
    localparam logic [7:0] K_F2     = 8'd142;
    localparam logic [7:0] K_F3     = 8'd143;
    localparam logic [7:0] K_F4     = 8'd144;
    localparam logic [7:0] K_F5     = 8'd145;
    localparam logic [7:0] K_F6     = 8'd146;
    localparam logic [7:0] K_F7     = 8'd147;
    localparam logic [7:0] K_F8     = 8'd148;
    localparam logic [7:0] K_F9     = 8'd149;
    localparam logic [7:0] K_F10    = 8'd150;
    localparam logic [7:0] K_F11    = 8'd151;
    localparam logic [7:0] K_F12    = 8'd152;

endpackage

// File: rtl/ps2_scancode_map.sv
// ps2_scancode_map: set-2 scan code (with E0 prefix and shift) to Hack key code lookup
module ps2_scancode_map
  import ps2_pkg::*;
(
  input  logic        ext_i,
  input  logic [7:0]  scan_i,
  input  logic        shift_i,
  output logic        valid_o,
  output logic [15:0] code_o
);
  logic       v;
  logic [7:0] lo;
  logic [7:0] hi;
  always_comb begin
    {v, lo, hi} = {1'b0, 8'd0, 8'd0};
    case ({ext_i, scan_i})
      9'h01C: {v, lo, hi} = {1'b1, "a", "A"};
      9'h032: {v, lo, hi} = {1'b1, "b", "B"};
      9'h021: {v, lo, hi} = {1'b1, "c", "C"};
      9'h023: {v, lo, hi} = {1'b1, "d", "D"};
      9'h024: {v, lo, hi} = {1'b1, "e", "E"};
      9'h02B: {v, lo, hi} = {1'b1, "f", "F"};
      9'h034: {v, lo, hi} = {1'b1, "g", "G"};
      9'h033: {v, lo, hi} = {1'b1, "h", "H"};
      9'h043: {v, lo, hi} = {1'b1, "i", "I"};
      9'h03B: {v, lo, hi} = {1'b1, "j", "J"};
      9'h042: {v, lo, hi} = {1'b1, "k", "K"};
      9'h04B: {v, lo, hi} = {1'b1, "l", "L"};
      9'h03A: {v, lo, hi} = {1'b1, "m", "M"};
      9'h031: {v, lo, hi} = {1'b1, "n", "N"};
      9'h044: {v, lo, hi} = {1'b1, "o", "O"};
      9'h04D: {v, lo, hi} = {1'b1, "p", "P"};
      9'h015: {v, lo, hi} = {1'b1, "q", "Q"};
      9'h02D: {v, lo, hi} = {1'b1, "r", "R"};
      9'h01B: {v, lo, hi} = {1'b1, "s", "S"};
      9'h02C: {v, lo, hi} = {1'b1, "t", "T"};
      9'h03C: {v, lo, hi} = {1'b1, "u", "U"};
      9'h02A: {v, lo, hi} = {1'b1, "v", "V"};
      9'h01D: {v, lo, hi} = {1'b1, "w", "W"};
      9'h022: {v, lo, hi} = {1'b1, "x", "X"};
      9'h035: {v, lo, hi} = {1'b1, "y", "Y"};
      9'h01A: {v, lo, hi} = {1'b1, "z", "Z"};
      9'h045: {v, lo, hi} = {1'b1, "0", ")"};
      9'h016: {v, lo, hi} = {1'b1, "1", "!"};
      9'h01E: {v, lo, hi} = {1'b1, "2", "@"};
      9'h026: {v, lo, hi} = {1'b1, "3", "#"};
      9'h025: {v, lo, hi} = {1'b1, "4", "$"};
      9'h02E: {v, lo, hi} = {1'b1, "5", "%"};
      9'h036: {v, lo, hi} = {1'b1, "6", "^"};
      9'h03D: {v, lo, hi} = {1'b1, "7", "&"};
      9'h03E: {v, lo, hi} = {1'b1, "8", "*"};
      9'h046: {v, lo, hi} = {1'b1, "9", "("};
      9'h029: {v, lo, hi} = {1'b1, " ", " "};
      9'h00E: {v, lo, hi} = {1'b1, 8'h60, "~"};
      9'h04E: {v, lo, hi} = {1'b1, "-", "_"};
      9'h055: {v, lo, hi} = {1'b1, "=", "+"};
      9'h054: {v, lo, hi} = {1'b1, "[", "{"};
      9'h05B: {v, lo, hi} = {1'b1, "]", "}"};
      9'h05D: {v, lo, hi} = {1'b1, "\\", "|"};
      9'h04C: {v, lo, hi} = {1'b1, ";", ":"};
      9'h052: {v, lo, hi} = {1'b1, "'", "\""};
      9'h041: {v, lo, hi} = {1'b1, ",", "<"};
      9'h049: {v, lo, hi} = {1'b1, ".", ">"};
      9'h04A: {v, lo, hi} = {1'b1, "/", "?"};
      9'h05A: {v, lo, hi} = {1'b1, K_ENTER, K_ENTER};
      9'h15A: {v, lo, hi} = {1'b1, K_ENTER, K_ENTER};
      9'h066: {v, lo, hi} = {1'b1, K_BKSP, K_BKSP};
      9'h076: {v, lo, hi} = {1'b1, K_ESC, K_ESC};
      9'h16B: {v, lo, hi} = {1'b1, K_LEFT, K_LEFT};
      9'h175: {v, lo, hi} = {1'b1, K_UP, K_UP};
      9'h174: {v, lo, hi} = {1'b1, K_RIGHT, K_RIGHT};
      9'h172: {v, lo, hi} = {1'b1, K_DOWN, K_DOWN};
      9'h16C: {v, lo, hi} = {1'b1, K_HOME, K_HOME};
      9'h169: {v, lo, hi} = {1'b1, K_END, K_END};
      9'h17D: {v, lo, hi} = {1'b1, K_PGUP, K_PGUP};
      9'h17A: {v, lo, hi} = {1'b1, K_PGDN, K_PGDN};
      9'h170: {v, lo, hi} = {1'b1, K_INSERT, K_INSERT};
      9'h171: {v, lo, hi} = {1'b1, K_DELETE, K_DELETE};
      9'h005: {v, lo, hi} = {1'b1, K_F1, K_F1};
      9'h006: {v, lo, hi} = {1'b1, K_F2, K_F2};
      9'h004: {v, lo, hi} = {1'b1, K_F3, K_F3};
      9'h00C: {v, lo, hi} = {1'b1, K_F4, K_F4};
      9'h003: {v, lo, hi} = {1'b1, K_F5, K_F5};
      9'h00B: {v, lo, hi} = {1'b1, K_F6, K_F6};
      9'h083: {v, lo, hi} = {1'b1, K_F7, K_F7};
      9'h00A: {v, lo, hi} = {1'b1, K_F8, K_F8};
      9'h001: {v, lo, hi} = {1'b1, K_F9, K_F9};
      9'h009: {v, lo, hi} = {1'b1, K_F10, K_F10};
      9'h078: {v, lo, hi} = {1'b1, K_F11, K_F11};
      9'h007: {v, lo, hi} = {1'b1, K_F12, K_F12};
      default: {v, lo, hi} = {1'b0, 8'd0, 8'd0};
    endcase
  end
  assign valid_o = v;
  assign code_o  = {8'd0, shift_i ? hi : lo};
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver with watchdog, scan-code decoder and held-key register
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        key_event,
    output logic        frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      c_sync_q, d_sync_q;
    logic            c_prev_q, fall_q, bit_q;
    rx_state_e       state_q, state_d;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      sr_q;
    logic            par_q, stop_q;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout, frame_ok, rx_err, byte_ok;
    logic            ext_q, ext_d, brk_q, brk_d, shl_q, shl_d, shr_q, shr_d;
    logic [15:0]     key_q, key_d;
    logic            event_q, err_q;
    logic            map_valid;
    logic [15:0]     map_code;

    // pins idle high, so the synchronizer resets to 1 and reset release makes no false edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            c_prev_q <= 1'b1;
            fall_q   <= 1'b0;
            bit_q    <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2_clk};
            d_sync_q <= {d_sync_q[0], ps2_data};
            c_prev_q <= c_sync_q[1];
            fall_q   <= c_prev_q & ~c_sync_q[1];
            bit_q    <= d_sync_q[1];
        end
    end

    // watchdog restarts on any PS/2 clock edge and only runs while a frame is open
    assign wd_d     = (c_prev_q ^ c_sync_q[1]) || state_q != ST_RECV ? '0 : wd_q + WD_W'(1);
    assign timeout  = state_q == ST_RECV && wd_q >= WD_W'(TIMEOUT_CYCLES);
    assign frame_ok = stop_q & (^{sr_q, par_q});

    // receiver state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // receiver next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = fall_q && !bit_q ? ST_RECV : ST_IDLE;
            ST_RECV: state_d = timeout ? ST_IDLE : fall_q && bit_cnt_q == 4'd9 ? ST_CHECK : ST_RECV;
            default: state_d = ST_IDLE;
        endcase
    end

    // receiver outputs: error on bad start bit, timeout or failed check; byte handoff on pass
    always_comb begin
        rx_err  = (state_q == ST_IDLE && fall_q && bit_q) || timeout || (state_q == ST_CHECK && !frame_ok);
        byte_ok = state_q == ST_CHECK && frame_ok;
    end

    // frame datapath: data LSB first into sr, then parity, then stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= 4'd0;
            sr_q      <= 8'd0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            wd_q      <= '0;
        end else begin
            wd_q <= wd_d;
            if (state_q == ST_IDLE) begin
                bit_cnt_q <= 4'd0;
            end else if (state_q == ST_RECV && fall_q && !timeout) begin
                if (bit_cnt_q < 4'd8) sr_q <= {bit_q, sr_q[7:1]};
                if (bit_cnt_q == 4'd8) par_q <= bit_q;
                if (bit_cnt_q == 4'd9) stop_q <= bit_q;
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end
    end

    ps2_scancode_map u_map (
        .ext_i   (ext_q),
        .scan_i  (sr_q),
        .shift_i (shl_q | shr_q),
        .valid_o (map_valid),
        .code_o  (map_code)
    );

    // prefix bytes set flags; any other byte consumes them; shift keys only touch shift state
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        shl_d = shl_q;
        shr_d = shr_q;
        key_d = key_q;
        if (byte_ok) begin
            if (sr_q == SC_E0) begin
                ext_d = 1'b1;
            end else if (sr_q == SC_F0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && sr_q == SC_LSHIFT)      shl_d = !brk_q;
                else if (!ext_q && sr_q == SC_RSHIFT) shr_d = !brk_q;
                else if (map_valid)                   key_d = !brk_q ? map_code : map_code == key_q ? 16'd0 : key_q;
            end
        end
    end

    // decoder state and output strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
            key_q   <= 16'd0;
            event_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            key_q   <= key_d;
            event_q <= key_d != key_q;
            err_q   <= rx_err;
        end
    end

    assign key_code  = key_q;
    assign key_event = event_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed frame sequences with counted key_event/frame_err strobes
module tb_ps2_keyboard;
    import ps2_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_code;
    logic        key_event;
    logic        frame_err;
    int          n_checks = 0;
    int          n_pass = 0;
    int          ev_cnt = 0;
    int          err_cnt = 0;

    ps2_keyboard #(.TIMEOUT_CYCLES(200)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event) ev_cnt <= ev_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 11, 1'b0);
    endtask

    initial begin
        wait_clk(3);
        @(negedge clk);
        chk("reset key_code", key_code, 0);
        chk("reset key_event", key_event, 0);
        chk("reset frame_err", frame_err, 0);
        reset = 1'b0;
        wait_clk(5);

        send(8'h1C);
        @(negedge clk);
        chk("make a", key_code, 97);
        chk("make a event", ev_cnt, 1);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("break a", key_code, 0);
        chk("break a event", ev_cnt, 2);
        chk("no errors yet", err_cnt, 0);

        send(8'h12);
        @(negedge clk);
        chk("shift alone", key_code, 0);
        send(8'h1C);
        @(negedge clk);
        chk("shift a", key_code, 65);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12);
        @(negedge clk);
        chk("shift A released", key_code, 0);
        send(8'h1C);
        @(negedge clk);
        chk("shift cleared", key_code, 97);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("shift seq events", ev_cnt, 6);

        send(8'hE0); send(8'h75);
        @(negedge clk);
        chk("up arrow", key_code, 131);
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        chk("up released", key_code, 0);
        send(8'h1C); send(8'h32);
        @(negedge clk);
        chk("make b over a", key_code, 98);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("break a keeps b", key_code, 98);
        send(8'hF0); send(8'h32);
        @(negedge clk);
        chk("overlap events", ev_cnt, 11);
        send(8'h1C); send(8'h1C);
        @(negedge clk);
        chk("typematic no event", ev_cnt, 12);
        send(8'hF0); send(8'h1C);

        send_bits(8'h1C, 11, 1'b1);
        @(negedge clk);
        chk("parity err", err_cnt, 1);
        chk("parity err key", key_code, 0);
        send(8'h1C);
        @(negedge clk);
        chk("after parity err", key_code, 97);
        send(8'hF0); send(8'h1C);

        ps2_bit(1'b1);
        wait_clk(10);
        @(negedge clk);
        chk("bad start bit", err_cnt, 2);

        send_bits(8'h16, 5, 1'b0);
        wait_clk(120);
        @(negedge clk);
        chk("no early timeout", err_cnt, 2);
        wait_clk(100);
        @(negedge clk);
        chk("timeout err", err_cnt, 3);
        chk("timeout idle", int'(dut.state_q), int'(ST_IDLE));
        send(8'h16);
        @(negedge clk);
        chk("digit 1", key_code, 49);
        send(8'hF0); send(8'h16);
        send(8'h59); send(8'h16);
        @(negedge clk);
        chk("rshift 1", key_code, 33);
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h59);
        @(negedge clk);
        chk("digit events", ev_cnt, 19);

        send(8'h1C);
        send_bits(8'h32, 3, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset key", key_code, 0);
        chk("async reset err", frame_err, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(3);
        @(negedge clk);
        reset = 1'b0;
        wait_clk(5);
        send(8'h1C);
        @(negedge clk);
        chk("after reset a", key_code, 97);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("after reset released", key_code, 0);
        chk("final err count", err_cnt, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
